// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional baud / oversample tick generator
//
// Derives a one-clock oversample tick (os_tick_o) and a one-clock baud tick
// (baud_tick_o, every OVERSAMPLE oversample ticks) from clk_i using an integer
// divisor plus an optional fractional accumulator.
//
// Optional feature macro: UART_BAUD_FRAC_EN
//   defined   - fractional accumulator/carry built, div_frac_i honoured
//   undefined - div_frac_i ignored, every period is exactly act_int clocks
//
// Ports:
//   clk_i        system clock
//   a_rst_n_i    asynchronous active-low reset
//   enable_i     run/stop; low holds counters at zero
//   div_int_i    integer divisor (clocks per oversample tick)
//   div_frac_i   fractional divisor (div_frac_i / 2^DIV_FRAC_WIDTH)
//   div_load_i   strobe capturing div_int_i/div_frac_i into the pending divisor
//   os_tick_o    one-clock pulse per oversample period
//   baud_tick_o  one-clock pulse per bit period, coincident with os_tick_o
//   cfg_err_o    sticky: last load was a divisor below 2 (clamped to 2)

module uart_baud_gen #(
    parameter int DIV_INT_WIDTH  = 16,
    parameter int DIV_FRAC_WIDTH = 4,
    parameter int OVERSAMPLE     = 16
) (
    input  logic                      clk_i,
    input  logic                      a_rst_n_i,
    input  logic                      enable_i,
    input  logic [DIV_INT_WIDTH-1:0]  div_int_i,
    input  logic [DIV_FRAC_WIDTH-1:0] div_frac_i,
    input  logic                      div_load_i,
    output logic                      os_tick_o,
    output logic                      baud_tick_o,
    output logic                      cfg_err_o
);

    localparam int PHASE_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [DIV_INT_WIDTH-1:0] DIV_MIN    = DIV_INT_WIDTH'(2);
    localparam logic [PHASE_W-1:0]       PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);

    logic [DIV_INT_WIDTH-1:0] act_int;
    logic [DIV_INT_WIDTH-1:0] pend_int;
    logic                     pend_vld;
    logic [DIV_INT_WIDTH-1:0] clk_cnt;
    logic [DIV_INT_WIDTH-1:0] cnt_last;
    logic [DIV_INT_WIDTH-1:0] ld_int;
    logic [PHASE_W-1:0]       phase;
    logic                     ld_bad;
    logic                     tick_now;

`ifdef UART_BAUD_FRAC_EN
    logic [DIV_FRAC_WIDTH-1:0] act_frac;
    logic [DIV_FRAC_WIDTH-1:0] pend_frac;
    logic [DIV_FRAC_WIDTH-1:0] frac_acc;
    logic [DIV_FRAC_WIDTH-1:0] ld_frac;
    logic                      carry;
`else
    logic unused_frac;
    assign unused_frac = ^div_frac_i;
`endif

    // Divisors below 2 would make back-to-back ticks; clamp to 2.0.
    assign ld_bad = (div_int_i < DIV_MIN);
    assign ld_int = ld_bad ? DIV_MIN : div_int_i;

`ifdef UART_BAUD_FRAC_EN
    assign ld_frac  = ld_bad ? '0 : div_frac_i;
    // A carry from the previous tick stretches this period by one clock.
    assign cnt_last = act_int - DIV_INT_WIDTH'(1) + DIV_INT_WIDTH'(carry);
`else
    assign cnt_last = act_int - DIV_INT_WIDTH'(1);
`endif

    // Evaluated only while enabled, so a tick due on the edge where enable
    // falls is dropped.
    assign tick_now = enable_i && (clk_cnt == cnt_last);

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            act_int     <= DIV_MIN;
            pend_int    <= '0;
            pend_vld    <= 1'b0;
            clk_cnt     <= '0;
            phase       <= '0;
            os_tick_o   <= 1'b0;
            baud_tick_o <= 1'b0;
            cfg_err_o   <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
            act_frac    <= '0;
            pend_frac   <= '0;
            frac_acc    <= '0;
            carry       <= 1'b0;
`endif
        end else begin
            os_tick_o   <= tick_now;
            baud_tick_o <= tick_now && (phase == PHASE_LAST);

            if (div_load_i) begin
                cfg_err_o <= ld_bad;
                pend_int  <= ld_int;
`ifdef UART_BAUD_FRAC_EN
                pend_frac <= ld_frac;
`endif
            end

            if (!enable_i) begin
                clk_cnt <= '0;
                phase   <= '0;
`ifdef UART_BAUD_FRAC_EN
                frac_acc <= '0;
                carry    <= 1'b0;
`endif
                // Stopped: nothing is in flight, so a new divisor goes live
                // straight away.
                if (div_load_i) begin
                    act_int  <= ld_int;
`ifdef UART_BAUD_FRAC_EN
                    act_frac <= ld_frac;
`endif
                    pend_vld <= 1'b0;
                end else if (pend_vld) begin
                    act_int  <= pend_int;
`ifdef UART_BAUD_FRAC_EN
                    act_frac <= pend_frac;
`endif
                    pend_vld <= 1'b0;
                end
            end else if (tick_now) begin
                clk_cnt <= '0;
                phase   <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
`ifdef UART_BAUD_FRAC_EN
                {carry, frac_acc} <= {1'b0, frac_acc} + {1'b0, act_frac};
`endif
                // Period boundary: swap in the divisor that was pending before
                // this edge; a load on this same edge waits for the next tick.
                if (pend_vld) begin
                    act_int  <= pend_int;
`ifdef UART_BAUD_FRAC_EN
                    act_frac <= pend_frac;
`endif
                end
                pend_vld <= div_load_i;
            end else begin
                clk_cnt <= clk_cnt + DIV_INT_WIDTH'(1);
                if (div_load_i) begin
                    pend_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen

module tb_uart_baud_gen;

`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_EN = 1'b1;
`else
    localparam bit FRAC_EN = 1'b0;
`endif
    localparam int LIMIT = 400;

    logic        clk_i = 1'b0;
    logic        a_rst_n_i;
    logic        enable_i;
    logic [15:0] div_int_i;
    logic [3:0]  div_frac_i;
    logic        div_load_i;
    logic        os_tick_o;
    logic        baud_tick_o;
    logic        cfg_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    uart_baud_gen #(
        .DIV_INT_WIDTH (16),
        .DIV_FRAC_WIDTH(4),
        .OVERSAMPLE    (16)
    ) dut (
        .clk_i      (clk_i),
        .a_rst_n_i  (a_rst_n_i),
        .enable_i   (enable_i),
        .div_int_i  (div_int_i),
        .div_frac_i (div_frac_i),
        .div_load_i (div_load_i),
        .os_tick_o  (os_tick_o),
        .baud_tick_o(baud_tick_o),
        .cfg_err_o  (cfg_err_o)
    );

    typedef struct {
        int di;
        int df;
        int p1;
        int p2;
        int p3_int;
        int p3_frac;
        int err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Negedges until os_tick_o is seen; -1 if the bound expires.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!os_tick_o && n < LIMIT);
        if (!os_tick_o) n = -1;
    endtask

    // Negedges until baud_tick_o, counting os ticks and baud ticks without os.
    task automatic run_to_baud(output int n, output int oses, output int orphan, output int first_os);
        n = 0; oses = 0; orphan = 0; first_os = -1;
        do begin
            @(negedge clk_i);
            n++;
            if (os_tick_o) begin
                oses++;
                if (first_os < 0) first_os = n;
            end
            if (baud_tick_o && !os_tick_o) orphan++;
        end while (!baud_tick_o && n < LIMIT);
        if (!baud_tick_o) n = -1;
    endtask

    // Stop, load a divisor (taken live immediately), leave stopped.
    task automatic stop_and_load(input int di, input int df);
        enable_i   = 1'b0;
        div_int_i  = 16'(di);
        div_frac_i = 4'(df);
        div_load_i = 1'b1;
        @(negedge clk_i);
        div_load_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        int n, m, oses, orphan, first_os, span;

        vecs[0] = '{di: 4, df: 0,  p1: 4, p2: 4, p3_int: 4, p3_frac: 4, err: 0};
        vecs[1] = '{di: 6, df: 8,  p1: 6, p2: 6, p3_int: 6, p3_frac: 7, err: 0};
        vecs[2] = '{di: 1, df: 0,  p1: 2, p2: 2, p3_int: 2, p3_frac: 2, err: 1};
        vecs[3] = '{di: 8, df: 0,  p1: 8, p2: 8, p3_int: 8, p3_frac: 8, err: 0};
        vecs[4] = '{di: 0, df: 5,  p1: 2, p2: 2, p3_int: 2, p3_frac: 2, err: 1};
        vecs[5] = '{di: 3, df: 15, p1: 3, p2: 3, p3_int: 3, p3_frac: 4, err: 0};
        vecs[6] = '{di: 2, df: 4,  p1: 2, p2: 2, p3_int: 2, p3_frac: 2, err: 0};

        a_rst_n_i  = 1'b0;
        enable_i   = 1'b0;
        div_int_i  = '0;
        div_frac_i = '0;
        div_load_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_os", int'(os_tick_o), 0);
        chk("reset_baud", int'(baud_tick_o), 0);
        chk("reset_err", int'(cfg_err_o), 0);
        a_rst_n_i = 1'b1;
        @(negedge clk_i);

        // Default divisor after reset is 2.
        enable_i = 1'b1;
        wait_tick(n); chk("default_p1", n, 2);
        wait_tick(n); chk("default_p2", n, 2);

        // Table: first three periods after a load while stopped.
        foreach (vecs[i]) begin
            stop_and_load(vecs[i].di, vecs[i].df);
            chk($sformatf("vec%0d_err", i), int'(cfg_err_o), vecs[i].err);
            enable_i = 1'b1;
            wait_tick(n); chk($sformatf("vec%0d_p1", i), n, vecs[i].p1);
            wait_tick(n); chk($sformatf("vec%0d_p2", i), n, vecs[i].p2);
            wait_tick(n);
            chk($sformatf("vec%0d_p3", i), n, FRAC_EN ? vecs[i].p3_frac : vecs[i].p3_int);
        end

        // Baud cadence at div 4: 16th os tick carries the baud tick.
        stop_and_load(4, 0);
        enable_i = 1'b1;
        run_to_baud(n, oses, orphan, first_os);
        chk("baud1_clocks", n, 64);
        chk("baud1_os_count", oses, 16);
        chk("baud1_orphan", orphan, 0);
        run_to_baud(n, oses, orphan, first_os);
        chk("baud2_clocks", n, 64);
        chk("baud2_os_count", oses, 16);

        // Fractional 6.5: 32 periods after the first span 208 clocks.
        stop_and_load(6, 8);
        enable_i = 1'b1;
        wait_tick(n);
        chk("frac_first", n, 6);
        span = 0;
        for (int k = 0; k < 32; k++) begin
            wait_tick(n);
            span += n;
        end
        chk("frac_span32", span, FRAC_EN ? 208 : 192);

        // Mid-period load: 10 completes, then 5.
        stop_and_load(10, 0);
        enable_i = 1'b1;
        wait_tick(n);
        chk("midload_first", n, 10);
        m = 0;
        repeat (2) begin @(negedge clk_i); m++; end
        div_int_i  = 16'd5;
        div_load_i = 1'b1;
        @(negedge clk_i); m++;
        div_load_i = 1'b0;
        wait_tick(n);
        chk("midload_old_period", n + m, 10);
        wait_tick(n); chk("midload_new_p1", n, 5);
        wait_tick(n); chk("midload_new_p2", n, 5);

        // Load on the tick edge: that tick keeps 5, the load waits one period.
        repeat (4) @(negedge clk_i);
        div_int_i  = 16'd7;
        div_load_i = 1'b1;
        @(negedge clk_i);
        div_load_i = 1'b0;
        chk("edgeload_tick", int'(os_tick_o), 1);
        wait_tick(n); chk("edgeload_still_old", n, 5);
        wait_tick(n); chk("edgeload_new", n, 7);

        // Enable drop two clocks before a due tick, 5 clocks off.
        stop_and_load(8, 0);
        enable_i = 1'b1;
        repeat (3) wait_tick(n);
        repeat (6) @(negedge clk_i);
        enable_i = 1'b0;
        oses = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (os_tick_o) oses++;
        end
        chk("gap_no_ticks", oses, 0);
        enable_i = 1'b1;
        run_to_baud(n, oses, orphan, first_os);
        chk("reenable_first_os", first_os, 8);
        chk("reenable_baud", n, 128);

        // Async reset mid-run with div 20.
        stop_and_load(20, 0);
        enable_i = 1'b1;
        wait_tick(n);
        chk("rst_pre_period", n, 20);
        div_int_i  = 16'd1;
        div_load_i = 1'b1;
        @(negedge clk_i);
        div_load_i = 1'b0;
        chk("rst_pre_err", int'(cfg_err_o), 1);
        repeat (5) @(negedge clk_i);
        #2 a_rst_n_i = 1'b0;
        #1;
        chk("rst_async_os", int'(os_tick_o), 0);
        chk("rst_async_err", int'(cfg_err_o), 0);
        @(negedge clk_i);
        a_rst_n_i = 1'b1;
        wait_tick(n); chk("post_rst_p1", n, 2);
        wait_tick(n); chk("post_rst_p2", n, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
